// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
// The FSM state type, the word geometry and the wait-counter sizing live here.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int MAX_WAIT   = 15;
    localparam int CNT_W      = $clog2(MAX_WAIT + 1);

    // True when no address bit above the implemented word range is set.
    function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
        return (addr >> (addr_w + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered read.
// A written byte lane returns the new data, so a store reads back the resulting word.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [WORD_BYTES-1:0] we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we[gi]) begin
                        lane_mem[addr] <= wdata[8*gi +: 8];
                        lane_rd_reg    <= wdata[8*gi +: 8];
                    end else begin
                        lane_rd_reg    <= lane_mem[addr];
                    end
                end
            end

            assign rdata[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory port: one load/store in flight, a fixed
// number of wait states, then a read word / write-back word / error response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_t state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  write_reg, write_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [WORD_BYTES-1:0] be_reg, be_next;
    logic                  err_reg, err_next;

    logic        req_err;
    logic        array_en;
    logic [3:0]  array_we;
    logic [31:0] array_rdata;

    assign req_err = (req_addr[1:0] != 2'b00) || !addr_in_range(req_addr, ADDR_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            write_reg <= write_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        write_next = write_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    write_next = req_write;
                    addr_next  = req_addr[ADDR_W+1:2];
                    wdata_next = req_wdata;
                    be_next    = req_be;
                    err_next   = req_err;
                    // Errored requests skip the array entirely.
                    if (req_err) begin
                        state_next = RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ACCESS;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                    err_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign array_en = (state_reg == ACCESS);
    assign array_we = write_reg ? be_reg : 4'b0000;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (array_en),
        .we    (array_we),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (array_rdata)
    );

    assign req_ready = rst && (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = err_reg;
    // The array read register only changes in ACCESS, so it is stable through RESP.
    assign rsp_rdata = (rsp_valid && !err_reg) ? array_rdata : 32'h0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the CPU data-memory port. It accepts load/store requests from the datapath over a valid/ready request channel and performs each access after a fixed, parameterised number of wait states. It returns a read word, write acknowledge or error over a valid/ready response channel. It replaces the zero-latency combinational data memory once the core moves to a handshaked memory interface.

## Interface
- `ADDR_W`, default 10: word-address bits. Depth is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 2: wait states before the array access. Legal range is 0..15.

- `clk`  in  1: rising-edge clock
- `rst`  in  1: reset, asynchronous, active-low
- `req_valid`  in  1: request present
- `req_ready`  out  1: responder can accept a request
- `req_write`  in  1: 1 = store, 0 = load
- `req_addr`  in  32: byte address
- `req_wdata`  in  32: store data
- `req_be`  in  4: store byte enables; bit i enables byte i (bits 8i+7:8i)
- `rsp_valid`  out  1: response present
- `rsp_ready`  in  1: requester accepts the response
- `rsp_rdata`  out  32: load data; post-write word for stores; 0 on error
- `rsp_err`  out  1: misaligned or out-of-range request

## Operation
- **States:** IDLE, WAIT, ACCESS, RESP.
- **IDLE:**
  - `req_ready` = 1; it is 1 only in IDLE and 0 while `rst` is low.
  - A request is accepted on an edge where `req_valid` && `req_ready`. `req_write`, `req_addr`, `req_wdata` and `req_be` are captured on that edge.
- **Error check at accept:**
  - The request is in error if `req_addr`[1:0] != 0, or if `req_addr`[31:ADDR_W+2] != 0.
  - An errored request goes IDLE→RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - An errored request never touches the array.
- **Valid request:**
  - If WAIT_CYCLES > 0: go to WAIT with the counter loaded to WAIT_CYCLES−1.
  - If WAIT_CYCLES = 0: go to ACCESS.
- **WAIT:** decrement the counter each edge; move to ACCESS on the edge where it is 0.
- **ACCESS:** one cycle; the array operation happens on the exiting edge, then the state moves to RESP.
  - **Store:** write enabled bytes only; disabled bytes are preserved.
  - **Store response:** `rsp_rdata` = the resulting full word.
  - **Load:** `rsp_rdata` = stored word at `req_addr`[ADDR_W+1:2]. `req_be` is ignored.
- **RESP:**
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` are held stable until `rsp_valid` && `rsp_ready`.
  - On that edge go to IDLE; `rsp_valid` drops and `rsp_err` clears.
- **No outstanding pipelining:** at most one transaction in flight. `req_valid` outside IDLE is ignored; the requester must hold it.
- **Reset:**
  - Outputs reset to `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0; state resets to IDLE and the counter to 0.
  - Array contents are not reset.
  - Reset mid-transaction aborts it. A store not yet past ACCESS is not performed, and no response is issued.

## Timing
- Count the accepting edge as edge 0.
- **Valid request:** `rsp_valid` rises after edge WAIT_CYCLES+1.
  - WAIT_CYCLES = 2: visible after edge 3.
  - WAIT_CYCLES = 0: visible after edge 1.
- **Errored request:** `rsp_valid` rises after edge 0.
- **Response handshake:** completes on the first edge with `rsp_ready` = 1 while in RESP, which may be the first RESP cycle. `req_ready` is 1 in the following cycle.
- **Back-to-back throughput** with `rsp_ready` tied high: one valid transaction per WAIT_CYCLES+3 cycles.
- **Array timing:**
  - Synchronous write and synchronous read on the ACCESS exit edge.
  - A load directly after a store to the same word returns the new data, because the transactions are serialised.

## Structure
- **Package `dmem_pkg`:**
  - state enum `dmem_state_t` {IDLE, WAIT, ACCESS, RESP}
  - `WORD_BYTES` = 4
  - `MAX_WAIT` = 15
- **Sub-module `dmem_array`:**
  - 2^ADDR_W × 32 single-port RAM
  - per-byte write enable
  - registered read
  - no reset
- **Top level:** FSM, wait counter, request capture registers, error check, response registers.

## Test plan
- **Store then load:** reset, then WAIT_CYCLES=2. Store 0xDEADBEEF to 0x10 with be=0xF, then load 0x10. Required: both responses after edge 3, with `rsp_rdata` = 0xDEADBEEF and `rsp_err` = 0.
- **Byte-enable store:** 0x11223344 at 0x20, then store 0xAABBCCDD with be=0x5. Required: store response = 0x11BB33DD, and a subsequent load returns 0x11BB33DD.
- **Misaligned load:** load 0x22. Required: `rsp_valid` after edge 0, `rsp_err` = 1, `rsp_rdata` = 0, and a later load of word 0x20 is unchanged.
- **Response backpressure and out-of-range:**
  - Hold `rsp_ready` = 0 for 5 cycles in RESP. Required: `rsp_rdata` stable and `req_ready` = 0 throughout; the handshake completes on the first `rsp_ready` = 1 edge.
  - With ADDR_W=10, load 0x1000. Required: `rsp_err` = 1.
- **WAIT_CYCLES=0 back-to-back:** 4 loads with `req_valid` and `rsp_ready` tied high. Required: one response every 3 cycles, each after edge 1.
- **Reset mid-store:** assert `rst` low in the WAIT cycle of a store of 0x55 to 0x30 (prior content 0x0). Required: outputs 0 immediately; after release, a load of 0x30 returns 0x0.
